reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order completion buffer that sits directly upstream of the reservation stations. It allocates one tag (RSV_ID) per dispatched instruction and captures results broadcast on the common data bus (CDB). It answers operand-tag queries from dispatch so the `filled` bits and data sent to a station are current. It retires completed results to the register file in allocation order.

## Interface
Parameters:
- `N_QUERY`, default 2: number of operand-query ports.
- `REG_W`, default 5: destination register index width.
- `RSV_ID_W`, `DATA_W`, `CDB_W` come from `fcpu_pkg`, not parameters. Depth is `2**RSV_ID_W`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `alloc_valid`  in  1  dispatch requests an entry.
- `alloc_dest`  in  `REG_W`  destination register of the instruction.
- `alloc_ready`  out  1  an entry is free.
- `alloc_id`  out  `RSV_ID_W`  tag that the current handshake receives (equals tail).
- `q_id`  in  `N_QUERY x RSV_ID_W`  tags being looked up.
- `q_filled`  out  `N_QUERY`  result for that tag is available.
- `q_data`  out  `N_QUERY x DATA_W`  result value; 0 when not filled.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb`  in  `CDB_W`  `{tag[DATA_W+:RSV_ID_W], data[DATA_W-1:0]}`.
- `o_valid`  out  1  head entry is complete.
- `o_id`  out  `RSV_ID_W`  head tag.
- `o_dest`  out  `REG_W`  head destination register.
- `o_data`  out  `DATA_W`  head result.
- `o_ready`  in  1  register file accepts the retirement.
- `count`  out  `RSV_ID_W+1`  number of occupied entries.

## Operation
- Circular buffer with head and tail pointers, each `RSV_ID_W+1` bits. The MSB is the wrap bit.
  - Empty: head == tail.
  - Full: index bits are equal and wrap bits differ.
- Per entry: `valid`, `done`, `dest`, `data`.
- **Allocate** on `alloc_valid && alloc_ready`:
  - `entry[tail]` ← `{valid=1, done=0, dest, data=0}`.
  - tail increments.
  - `alloc_ready = !full`, computed from registered state only. A retirement in the same cycle does not free space for that cycle.
- **CDB capture:** when `cdb_valid`, the entry at the tag is written with `data`, `done=1` if that entry is currently `valid && !done`.
  - A CDB to an invalid entry is ignored.
  - A CDB to an already-done entry is ignored (first write wins).
  - A CDB to the entry being allocated in the same cycle is ignored, because that entry is not yet valid.
- **Query (combinational, per port k):**
  - `q_filled[k] = entry.valid && (entry.done || (cdb_valid && cdb tag == q_id[k]))`.
  - `q_data[k]` is the entry data, or the CDB data when bypassing.
  - Otherwise `q_filled=0` and `q_data=0`.
- **Retire:**
  - `o_valid = entry[head].valid && entry[head].done`, from registers only (no CDB bypass).
  - On `o_valid && o_ready`: `entry[head].valid` and `done` are cleared and head increments.
  - `o_id`, `o_dest`, `o_data` are driven from head and held stable while `o_valid && !o_ready`.
- **Simultaneous events:** alloc, CDB and retire in one cycle all take effect. `count` = count + alloc − retire.
- **Reset (asynchronous, `nrst` = 0), effective immediately and also mid-operation:** all entries invalid, head = tail = 0, in-flight results dropped. Output values under reset:
  - `alloc_ready` = 1, `alloc_id` = 0.
  - `o_valid` = 0, `o_id` / `o_dest` / `o_data` = 0.
  - `q_filled` = 0, `q_data` = 0.
  - `count` = 0.

## Timing
- Alloc at cycle t: the entry is visible to queries and CDB capture from t+1.
- CDB at cycle t: query bypass at t (zero latency); `done` registered at t+1; `o_valid` at t+1 if the entry is head.
- Retirement throughput is 1 per cycle. Back-to-back completed entries retire on consecutive cycles while `o_ready` is high.
- Full boundary: after `2**RSV_ID_W` allocations with no retirement, `alloc_ready` = 0. It reasserts in the cycle after the first retirement.
- Wrap: tags reuse index 0 after index `2**RSV_ID_W−1`; the wrap bit toggles.

## Structure
- `fcpu_pkg` holds:
  - `RSV_ID_W`, `DATA_W`, `CDB_W = RSV_ID_W + DATA_W`.
  - typedef `rob_entry_t` (valid, done, dest, data).
  - typedef `rob_ptr_t` (`RSV_ID_W+1` bits).
- One sub-module: `rob_query_port`, the per-port combinational lookup with CDB bypass. It is instantiated `N_QUERY` times through generate.

## Test plan
Test configuration: `RSV_ID_W` = 4, `DATA_W` = 32.
- Reset, then 3 allocs with dest 1, 2, 3 → `alloc_id` 0, 1, 2; `count` = 3; `o_valid` = 0.
- CDB tag 1 data 0xAA, then tag 0 data 0x55 → `o_valid` rises the cycle after the tag 0 write. Retires are (id 0, dest 1, 0x55) then (id 1, dest 2, 0xAA) on consecutive cycles.
- Query `q_id` = 2 while CDB tag 2 data 0x1234 is on the bus → `q_filled` = 1, `q_data` = 0x1234 in the same cycle. Query of an unallocated tag 9 → 0/0.
- 16 allocs with no retire → `alloc_ready` = 0 and `count` = 16. A 17th `alloc_valid` is not accepted. Retire once → `alloc_ready` = 1 next cycle, and the new `alloc_id` = 0 (wrap).
- Second CDB to done tag 0 with 0xFF → the entry keeps its first value. Hold `o_ready` = 0 for 3 cycles → outputs stay stable.
- Assert `nrst` low mid-stream with 5 entries in flight → outputs immediately return to their reset values; `count` = 0.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared widths and types for the reorder buffer and its query ports.
package fcpu_pkg;
  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;
  localparam int DEST_W   = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // MSB is the wrap bit; the low RSV_ID_W bits index the entry array.
  typedef logic [RSV_ID_W:0] rob_ptr_t;
endpackage

// File: rtl/rob_query_port.sv
// One operand-tag lookup: returns completed data, or bypasses a CDB result
// broadcast to a valid but not-yet-done entry in the same cycle.
module rob_query_port
  import fcpu_pkg::*;
#(
  parameter int DEPTH = 2**RSV_ID_W
) (
  input  logic [RSV_ID_W-1:0]            q_id,
  input  logic [DEPTH-1:0]               ent_valid,
  input  logic [DEPTH-1:0]               ent_done,
  input  logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
  input  logic                           cdb_valid,
  input  logic [RSV_ID_W-1:0]            cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           q_filled,
  output logic [DATA_W-1:0]              q_data
);
  always_comb begin
    q_filled = 1'b0;
    q_data   = '0;
    if (ent_valid[q_id]) begin
      // Stored result wins over the bus: a done entry ignores later broadcasts.
      if (ent_done[q_id]) begin
        q_filled = 1'b1;
        q_data   = ent_data[q_id];
      end else if (cdb_valid && cdb_tag == q_id) begin
        q_filled = 1'b1;
        q_data   = cdb_data;
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tags at dispatch, captures CDB
// results, answers operand queries, and retires to the register file in order.
module reorder_buffer
  import fcpu_pkg::*;
#(
  parameter int N_QUERY = 2,
  parameter int REG_W   = 5
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               alloc_valid,
  input  logic [REG_W-1:0]                   alloc_dest,
  output logic                               alloc_ready,
  output logic [RSV_ID_W-1:0]                alloc_id,
  input  logic [N_QUERY-1:0][RSV_ID_W-1:0]   q_id,
  output logic [N_QUERY-1:0]                 q_filled,
  output logic [N_QUERY-1:0][DATA_W-1:0]     q_data,
  input  logic                               cdb_valid,
  input  logic [CDB_W-1:0]                   cdb,
  output logic                               o_valid,
  output logic [RSV_ID_W-1:0]                o_id,
  output logic [REG_W-1:0]                   o_dest,
  output logic [DATA_W-1:0]                  o_data,
  input  logic                               o_ready,
  output logic [RSV_ID_W:0]                  count
);
  localparam int DEPTH = 2**RSV_ID_W;

  rob_entry_t                  ent [DEPTH];
  rob_ptr_t                    head, tail;
  logic [RSV_ID_W-1:0]         head_idx, tail_idx, cdb_tag;
  logic [DATA_W-1:0]           cdb_data;
  logic                        full, alloc_fire, retire_fire, cdb_hit;
  logic [DEPTH-1:0]            ent_valid, ent_done;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  assign head_idx = head[RSV_ID_W-1:0];
  assign tail_idx = tail[RSV_ID_W-1:0];
  assign cdb_tag  = cdb[DATA_W +: RSV_ID_W];
  assign cdb_data = cdb[DATA_W-1:0];

  // Full is taken from registered pointers only, so a same-cycle retire
  // does not open a slot until the next cycle.
  assign full        = (head[RSV_ID_W] != tail[RSV_ID_W]) && (head_idx == tail_idx);
  assign alloc_ready = !full;
  assign alloc_id    = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign o_valid     = ent[head_idx].valid && ent[head_idx].done;
  assign o_id        = head_idx;
  assign o_dest      = REG_W'(ent[head_idx].dest);
  assign o_data      = ent[head_idx].data;
  assign retire_fire = o_valid && o_ready;
  assign count       = tail - head;

  assign cdb_hit = cdb_valid && ent[cdb_tag].valid && !ent[cdb_tag].done;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ent_valid[i] = ent[i].valid;
    assign ent_done[i]  = ent[i].done;
    assign ent_data[i]  = ent[i].data;
  end

  for (genvar k = 0; k < N_QUERY; k++) begin : g_q
    rob_query_port #(.DEPTH(DEPTH)) u_q (
      .q_id      (q_id[k]),
      .ent_valid (ent_valid),
      .ent_done  (ent_done),
      .ent_data  (ent_data),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .q_filled  (q_filled[k]),
      .q_data    (q_data[k])
    );
  end

  // Retire, capture and allocate always touch distinct entries: the retiring
  // head is already done, and the tail entry is invalid whenever alloc fires.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (retire_fire) begin
        ent[head_idx].valid <= 1'b0;
        ent[head_idx].done  <= 1'b0;
        head                <= head + 1'b1;
      end
      if (cdb_hit) begin
        ent[cdb_tag].done <= 1'b1;
        ent[cdb_tag].data <= cdb_data;
      end
      if (alloc_fire) begin
        ent[tail_idx].valid <= 1'b1;
        ent[tail_idx].done  <= 1'b0;
        ent[tail_idx].dest  <= DEST_W'(alloc_dest);
        ent[tail_idx].data  <= '0;
        tail                <= tail + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_reorder_buffer;
  import fcpu_pkg::*;
  localparam int NQ = 2;
  localparam int RW = 5;
  localparam int DEPTH = 16;

  logic                          clk = 1'b0;
  logic                          nrst = 1'b1;
  logic                          alloc_valid = 1'b0;
  logic [RW-1:0]                 alloc_dest = '0;
  logic                          alloc_ready;
  logic [3:0]                    alloc_id;
  logic [NQ-1:0][3:0]            q_id = '0;
  logic [NQ-1:0]                 q_filled;
  logic [NQ-1:0][31:0]           q_data;
  logic                          cdb_valid = 1'b0;
  logic [35:0]                   cdb = '0;
  logic                          o_valid;
  logic [3:0]                    o_id;
  logic [RW-1:0]                 o_dest;
  logic [31:0]                   o_data;
  logic                          o_ready = 1'b0;
  logic [4:0]                    count;

  always #5 clk = ~clk;

  reorder_buffer #(.N_QUERY(NQ), .REG_W(RW)) dut (
    .clk(clk), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .q_id(q_id), .q_filled(q_filled), .q_data(q_data),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .o_valid(o_valid), .o_id(o_id), .o_dest(o_dest), .o_data(o_data),
    .o_ready(o_ready), .count(count)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: tags in allocation order plus per-tag completion state.
  int          order[$];
  bit          m_done[DEPTH];
  logic [31:0] m_data[DEPTH];
  logic [RW-1:0] m_dest[DEPTH];
  int          next_tag = 0;
  bit          m_fa, m_fr;
  int          m_ct;

  function automatic bit in_q(input int t);
    foreach (order[i]) if (order[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      order.delete();
      next_tag = 0;
      for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
    end else begin
      m_fa = alloc_valid && (order.size() < DEPTH);
      m_fr = o_ready && (order.size() > 0) && m_done[order[0]];
      m_ct = int'(cdb[35:32]);
      if (cdb_valid && in_q(m_ct) && !m_done[m_ct]) begin
        m_done[m_ct] = 1'b1;
        m_data[m_ct] = cdb[31:0];
      end
      if (m_fr) begin
        m_done[order[0]] = 1'b0;
        void'(order.pop_front());
      end
      if (m_fa) begin
        order.push_back(next_tag);
        m_done[next_tag] = 1'b0;
        m_data[next_tag] = '0;
        m_dest[next_tag] = alloc_dest;
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  task automatic compare();
    int sz;
    bit ov;
    int t;
    bit f;
    logic [31:0] d;
    sz = order.size();
    ov = (sz > 0) && m_done[order[0]];
    chk("model_alloc_ready", alloc_ready, sz < DEPTH);
    chk("model_alloc_id", alloc_id, next_tag);
    chk("model_count", count, sz);
    chk("model_o_valid", o_valid, ov);
    chk("model_o_id", o_id, (sz > 0) ? order[0] : next_tag);
    if (ov) begin
      chk("model_o_dest", o_dest, m_dest[order[0]]);
      chk("model_o_data", o_data, m_data[order[0]]);
    end
    for (int k = 0; k < NQ; k++) begin
      t = int'(q_id[k]);
      f = 1'b0;
      d = '0;
      if (in_q(t)) begin
        if (m_done[t]) begin
          f = 1'b1; d = m_data[t];
        end else if (cdb_valid && int'(cdb[35:32]) == t) begin
          f = 1'b1; d = cdb[31:0];
        end
      end
      chk($sformatf("model_q_filled%0d", k), q_filled[k], f);
      chk($sformatf("model_q_data%0d", k), q_data[k], d);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) compare();
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_alloc_ready"}, alloc_ready, 1);
    chk({tag, "_alloc_id"}, alloc_id, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_id"}, o_id, 0);
    chk({tag, "_o_dest"}, o_dest, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_q_filled"}, q_filled, 0);
    chk({tag, "_q_data"}, q_data, 0);
  endtask

  initial begin
    #1 nrst = 1'b0;
    #1 chk_reset_vals("reset");
    chk_en = 1'b1;
    @(negedge clk) nrst = 1'b1;

    // Three allocations
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_dest = RW'(i + 1);
      #3 chk($sformatf("alloc_id_%0d", i), alloc_id, i);
    end
    @(negedge clk) alloc_valid = 1'b0;
    #3 chk("count_3", count, 3);
    chk("o_valid_idle", o_valid, 0);

    // Out-of-order completion, tag 1 then tag 0
    @(negedge clk) begin cdb_valid = 1'b1; cdb = {4'd1, 32'hAA}; end
    @(negedge clk) cdb = {4'd0, 32'h55};
    #3 chk("o_valid_before_tag0", o_valid, 0);
    @(negedge clk) cdb_valid = 1'b0;
    #3 chk("o_valid_after_tag0", o_valid, 1);
    chk("head_id", o_id, 0);
    chk("head_dest", o_dest, 1);
    chk("head_data", o_data, 32'h55);

    // Stall three cycles; a second broadcast to done tag 0 must not stick
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cdb_valid = (i == 0); cdb = {4'd0, 32'hFF};
      #3 chk($sformatf("stall_o_valid_%0d", i), o_valid, 1);
      chk($sformatf("stall_o_id_%0d", i), o_id, 0);
      chk($sformatf("stall_o_data_%0d", i), o_data, 32'h55);
      chk($sformatf("stall_q_data_%0d", i), q_data[0], 32'h55);
    end

    // Back-to-back retirement
    @(negedge clk) begin cdb_valid = 1'b0; o_ready = 1'b1; end
    #3 chk("ret0_valid", o_valid, 1);
    chk("ret0_id", o_id, 0);
    chk("ret0_dest", o_dest, 1);
    chk("ret0_data", o_data, 32'h55);
    @(negedge clk);
    #3 chk("ret1_valid", o_valid, 1);
    chk("ret1_id", o_id, 1);
    chk("ret1_dest", o_dest, 2);
    chk("ret1_data", o_data, 32'hAA);

    // Zero-latency bypass and query of an unallocated tag
    @(negedge clk) begin
      q_id[0] = 4'd2; q_id[1] = 4'd9;
      cdb_valid = 1'b1; cdb = {4'd2, 32'h1234};
    end
    #3 chk("byp_o_valid", o_valid, 0);
    chk("byp_filled", q_filled[0], 1);
    chk("byp_data", q_data[0], 32'h1234);
    chk("unalloc_filled", q_filled[1], 0);
    chk("unalloc_data", q_data[1], 0);
    @(negedge clk) cdb_valid = 1'b0;
    #3 chk("ret2_valid", o_valid, 1);
    chk("ret2_data", o_data, 32'h1234);
    @(negedge clk) o_ready = 1'b0;
    #3 chk("drained_count", count, 0);

    // Full boundary and wrap
    nrst = 1'b0;
    @(negedge clk) nrst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_dest = RW'(i);
      #3 chk($sformatf("fill_id_%0d", i), alloc_id, i);
    end
    @(negedge clk) begin cdb_valid = 1'b1; cdb = {4'd0, 32'h77}; end
    #3 chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    @(negedge clk) begin cdb_valid = 1'b0; o_ready = 1'b1; end
    #3 chk("no_17th_count", count, 16);
    chk("retire_cycle_ready", alloc_ready, 0);
    chk("full_head_valid", o_valid, 1);
    @(negedge clk) o_ready = 1'b0;
    #3 chk("after_retire_ready", alloc_ready, 1);
    chk("wrap_id", alloc_id, 0);
    chk("after_retire_count", count, 15);
    @(negedge clk) alloc_valid = 1'b0;
    #3 chk("refill_count", count, 16);

    // Reset mid-stream with five in flight
    nrst = 1'b0;
    @(negedge clk) nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_dest = RW'(10 + i);
    end
    @(negedge clk) begin alloc_valid = 1'b0; cdb_valid = 1'b1; cdb = {4'd0, 32'h99}; end
    @(negedge clk) begin cdb_valid = 1'b0; q_id[0] = 4'd0; end
    #1 chk("pre_rst_o_valid", o_valid, 1);
    chk("pre_rst_count", count, 5);
    #2 nrst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk) nrst = 1'b1;
    @(negedge clk);
    #3 chk("post_rst_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
